fpunwrap: RTL and testbench

Iterative fixed-point multiple-add unit: computes `out = num1 + k*num2` in sign-magnitude Q(N-Q).Q by repeated addition, one add per clock. It is the reconstruction counterpart of the encoder's fixed-point modulus block. The modulus block strips whole multiples of a period, such as 2π for phase wrapping. This block restores a signed number of periods to a wrapped value, for phase unwrapping and track reconstruction on the decode side. It uses the same start/done handshake as the other iterative fixed-point units in the datapath.

---
 rtl/fpunwrap.sv | 128 ++++++++++++
 tb/tb_fpunwrap.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fpunwrap.sv
// Iterative sign-magnitude multiple-add: out = num1 + k*num2, one add per clock.
// Restores a signed number of periods to a wrapped fixed-point value.
//
// state | meaning
// IDLE  | waiting for startunwrap, inputs captured on accept
// LOAD  | normalize num1 into acc, derive signed step and |k|
// ADD   | acc += step once per clock until count reaches zero
// DONE  | publish acc on out, pulse doneunwrap
module fpunwrap #(
  parameter int N  = 32,
  parameter int Q  = 16,
  parameter int KW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          startunwrap,
  input  logic [N-1:0]  num1,
  input  logic [N-1:0]  num2,
  input  logic [KW-1:0] k,
  output logic [N-1:0]  out,
  output logic          doneunwrap,
  output logic          busy,
  output logic          ovf
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ADD, S_DONE} state_t;

  localparam logic [N-2:0] MAG_MAX = '1;

  state_t        state_q;
  logic [N-1:0]  n1_q, n2_q;
  logic [KW-1:0] k_q;
  logic [N-1:0]  acc_q, step_q;
  logic [KW-1:0] cnt_q;
  logic [N-1:0]  out_q;
  logic          done_q, busy_q, ovf_q;
  logic [N:0]    add_res;

  // Q only fixes the binary point; the arithmetic is identical for any Q.
  logic [31:0]   unused_q;
  assign unused_q = 32'(Q);

  // Returns {overflow, result}; -0 operands read as +0 and -0 is never produced.
  function automatic logic [N:0] sm_add(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-2:0] ma, mb, mr;
    logic [N-1:0] sum;
    logic         sa, sb, sr, of;
    ma  = a[N-2:0];
    mb  = b[N-2:0];
    sa  = a[N-1] & (|ma);
    sb  = b[N-1] & (|mb);
    sum = {1'b0, ma} + {1'b0, mb};
    of  = 1'b0;
    sr  = sa;
    if (sa == sb) begin
      if (sum[N-1]) begin
        mr = MAG_MAX;
        of = 1'b1;
      end else begin
        mr = sum[N-2:0];
      end
    end else if (ma >= mb) begin
      mr = ma - mb;
      sr = sa;
    end else begin
      mr = mb - ma;
      sr = sb;
    end
    return {of, sr & (|mr), mr};
  endfunction

  assign add_res = sm_add(acc_q, step_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      n1_q    <= '0;
      n2_q    <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      step_q  <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          busy_q <= startunwrap;
          if (startunwrap) begin
            n1_q    <= num1;
            n2_q    <= num2;
            k_q     <= k;
            ovf_q   <= 1'b0;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          acc_q  <= {n1_q[N-1] & (|n1_q[N-2:0]), n1_q[N-2:0]};
          step_q <= {n2_q[N-1] ^ k_q[KW-1], n2_q[N-2:0]};
          // |k| fits in KW unsigned bits, including k = -2^(KW-1)
          cnt_q  <= k_q[KW-1] ? (~k_q + 1'b1) : k_q;
          state_q <= (k_q == '0) ? S_DONE : S_ADD;
        end
        S_ADD: begin
          acc_q <= add_res[N-1:0];
          if (add_res[N]) ovf_q <= 1'b1;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == KW'(1)) state_q <= S_DONE;
        end
        S_DONE: begin
          out_q   <= acc_q;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out        = out_q;
  assign doneunwrap = done_q;
  assign busy       = busy_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_fpunwrap.sv
// Scoreboard bench for fpunwrap: driver pushes integer-model results, a
// negedge monitor pops and compares them whenever doneunwrap is seen.
module tb_fpunwrap;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        startunwrap = 1'b0;
  logic [31:0] num1 = '0, num2 = '0;
  logic [7:0]  k = '0;
  logic [31:0] out;
  logic        doneunwrap, busy, ovf;

  fpunwrap #(.N(32), .Q(16), .KW(8)) dut (
    .clk(clk), .rst(rst), .startunwrap(startunwrap),
    .num1(num1), .num2(num2), .k(k),
    .out(out), .doneunwrap(doneunwrap), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        of;
    int          lat;
    int          c0;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain signed-integer arithmetic with magnitude clamp.
  function automatic longint sm2int(input logic [31:0] v);
    longint m = longint'(v[30:0]);
    return v[31] ? -m : m;
  endfunction

  function automatic logic [31:0] int2sm(input longint v);
    logic [30:0] m;
    if (v < 0) begin
      m = 31'(-v);
      return {1'b1, m};
    end
    m = 31'(v);
    return {1'b0, m};
  endfunction

  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [7:0] kk,
                       output logic [31:0] r, output logic o, output int n);
    longint mx = 64'h7FFF_FFFF;
    longint acc = sm2int(a);
    longint st = sm2int(b);
    int kv = int'($signed(kk));
    n = (kv < 0) ? -kv : kv;
    if (kv < 0) st = -st;
    o = 1'b0;
    for (int i = 0; i < n; i++) begin
      acc = acc + st;
      if (acc > mx) begin acc = mx; o = 1'b1; end
      else if (acc < -mx) begin acc = -mx; o = 1'b1; end
    end
    r = int2sm(acc);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst && doneunwrap) begin
      chk("done_width", {31'b0, prev_done}, 32'd0);
      chk("busy_at_done", {31'b0, busy}, 32'd1);
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got out=%h with empty scoreboard", out);
      end else begin
        e = sb_q.pop_front();
        chk("out", out, e.res);
        chk("ovf", {31'b0, ovf}, {31'b0, e.of});
        chk("latency", 32'(cyc - e.c0), 32'(e.lat));
      end
    end
    prev_done = doneunwrap;
  end

  // Issue one op on the next edge; optionally wait for its completion.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [7:0] kk,
                       input bit wait_done);
    exp_t e;
    int   n;
    bit   seen;
    @(negedge clk);
    num1 = a; num2 = b; k = kk; startunwrap = 1'b1;
    model(a, b, kk, e.res, e.of, n);
    e.lat = n + 2;
    e.c0  = cyc + 1;
    sb_q.push_back(e);
    @(negedge clk);
    startunwrap = 1'b0;
    num1 = $urandom; num2 = $urandom; k = 8'($urandom);
    chk("busy_after_start", {31'b0, busy}, 32'd1);
    chk("ovf_cleared", {31'b0, ovf}, 32'd0);
    if (wait_done) begin
      seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
        if (doneunwrap) seen = 1'b1;
        else @(negedge clk);
      end
      chk("done_seen", {31'b0, seen}, 32'd1);
      @(negedge clk);
      chk("busy_after_done", {31'b0, busy}, 32'd0);
    end
  endtask

  task automatic wait_idle();
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (doneunwrap) seen = 1'b1;
    end
    chk("done_seen", {31'b0, seen}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] a, b;
    logic [7:0]  kk;
    #1;
    chk("rst_out", out, 32'd0);
    chk("rst_done", {31'b0, doneunwrap}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ovf", {31'b0, ovf}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    issue(32'h0001_0000, 32'h0006_487E, 8'd2, 1);
    issue(32'h0001_0000, 32'h0006_487E, 8'hFF, 1);
    issue(32'h8000_0000, 32'h1234_5678, 8'd0, 1);
    issue(32'h0003_0000, 32'h8003_0000, 8'd1, 1);
    issue(32'h7FFF_0000, 32'h0002_0000, 8'd1, 1);
    issue(32'h0000_1000, 32'h0000_0010, 8'd3, 1);
    issue(32'h8001_0000, 32'h8000_0000, 8'd5, 1);

    // Max count with a start pulse mid-run that must be ignored.
    issue(32'h0, 32'h0000_0001, 8'h80, 0);
    repeat (50) @(negedge clk);
    num1 = 32'h1111_1111; num2 = 32'h2222_2222; k = 8'd3; startunwrap = 1'b1;
    @(negedge clk);
    startunwrap = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);

    // Reset mid-run aborts with no done pulse.
    issue(32'h0000_0100, 32'h0001_0000, 8'd10, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    #1;
    chk("mid_rst_out", out, 32'd0);
    chk("mid_rst_done", {31'b0, doneunwrap}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (15) @(negedge clk);
    chk("post_rst_out", out, 32'd0);
    issue(32'h0, 32'h0001_0000, 8'd1, 1);

    for (int t = 0; t < 40; t++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? $urandom : {$urandom_range(0, 1) == 1, 11'b0, 20'($urandom)};
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 9) == 0) b = {$urandom_range(0, 1) == 1, 31'b0};
      kk = 8'($signed($urandom_range(0, 40)) - 20);
      if ($urandom_range(0, 9) == 0) kk = 8'($urandom);
      issue(a, b, kk, 1);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL timeout: simulation did not complete, got t=%0t expected finish", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1);
  end

endmodule
